// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq: iterative AES-128 InvMixColumns, COLS_PER_CYCLE columns per busy cycle.
// Optional in_bypass port (copy columns unchanged) when INV_MIX_COLUMNS_BYPASS_EN is defined.
module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef INV_MIX_COLUMNS_BYPASS_EN
  input  logic         in_bypass,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  localparam int N = 4 / COLS_PER_CYCLE;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, nxt;
  logic [1:0] cnt;
  logic [3:0][31:0] w, wn;
  logic [1:0] idx [COLS_PER_CYCLE];
  logic byp, last, acc;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] mul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] b2, b4, b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? b2 : 8'h00) ^ (k[2] ? b4 : 8'h00) ^ (k[3] ? b8 : 8'h00);
  endfunction
  function automatic logic [31:0] xf(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    {s0, s1, s2, s3} = c;
    return {mul(s0, 4'he) ^ mul(s1, 4'hb) ^ mul(s2, 4'hd) ^ mul(s3, 4'h9),
            mul(s0, 4'h9) ^ mul(s1, 4'he) ^ mul(s2, 4'hb) ^ mul(s3, 4'hd),
            mul(s0, 4'hd) ^ mul(s1, 4'h9) ^ mul(s2, 4'he) ^ mul(s3, 4'hb),
            mul(s0, 4'hb) ^ mul(s1, 4'hd) ^ mul(s2, 4'h9) ^ mul(s3, 4'he)};
  endfunction
  assign in_ready = (state == IDLE) && !rst;
  assign acc = in_valid && in_ready;
  assign last = cnt == 2'(N - 1);
  // column c lives in w[3-c], i.e. w[~c] for a 2-bit index
  always_comb begin
    wn = w;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      idx[k] = 2'(int'(cnt) * COLS_PER_CYCLE + k);
      wn[~idx[k]] = byp ? w[~idx[k]] : xf(w[~idx[k]]);
    end
  end
  always_comb begin
    nxt = (state == IDLE && in_valid) ? BUSY :
          (state == BUSY && last) ? DONE :
          (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      w <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (acc) begin
      w <= in_data;
      cnt <= '0;
    end else if (state == BUSY) begin
      w <= wn;
      cnt <= last ? 2'd0 : cnt + 2'd1;
      if (last) begin
        out_data <= wn;
        out_valid <= 1'b1;
      end
    end else if (state == DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end
`ifdef INV_MIX_COLUMNS_BYPASS_EN
  always_ff @(posedge clk) byp <= rst ? 1'b0 : acc ? in_bypass : byp;
`else
  assign byp = 1'b0;
`endif
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb_inv_mix_columns_seq: vector table, random model check, backpressure, reset and wide-datapath cases.
module tb_inv_mix_columns_seq;
  logic clk = 0, rst = 1, byp = 0;
  logic v1 = 0, rdy1, ov1, or1 = 1;
  logic [127:0] d1 = '0, od1;
  logic v4 = 0, rdy4, ov4, or4 = 1;
  logic [127:0] d4 = '0, od4;
  int cmp = 0, err = 0;
  typedef struct {logic [127:0] din; logic [127:0] exp;} vec_t;
  vec_t tv [4];
  always #5 clk = ~clk;
  inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
`ifdef INV_MIX_COLUMNS_BYPASS_EN
    .in_bypass(byp),
`endif
    .out_valid(ov1), .out_ready(or1), .out_data(od1));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
`ifdef INV_MIX_COLUMNS_BYPASS_EN
    .in_bypass(1'b0),
`endif
    .out_valid(ov4), .out_ready(or4), .out_data(od4));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [127:0] model(input logic [127:0] din, input logic b);
    logic [7:0] k [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [7:0] s [4];
    logic [127:0] r = '0;
    if (b) return din;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) s[j] = din[127 - 32*c - 8*j -: 8];
      for (int i = 0; i < 4; i++) begin
        logic [7:0] acc = 0;
        for (int j = 0; j < 4; j++) acc ^= gmul(k[(j - i + 4) % 4], s[j]);
        r[127 - 32*c - 8*i -: 8] = acc;
      end
    end
    return r;
  endfunction
  function automatic logic [127:0] rnd;
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic xfer1(input logic [127:0] din, input logic b, output logic [127:0] res, output int lat);
    int n = 0;
    while (!rdy1 && n < 20) begin tick; n++; end
    chk("in_ready wait", rdy1, 1);
    v1 = 1; d1 = din; byp = b;
    tick;
    v1 = 0; d1 = rnd(); byp = 0;
    lat = 0;
    while (!ov1 && lat < 20) begin tick; lat++; end
    res = od1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [127:0] res, x, y;
    int lat, n;
    logic seen;
    tv[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
    tv[1] = '{128'hd5d5d7d6_4d7ebdf8_c6c6c6c6_01010101, 128'hd4d4d4d5_2d26314c_c6c6c6c6_01010101};
    tv[2] = '{128'h0, 128'h0};
    tv[3] = '{{128{1'b1}}, {128{1'b1}}};
    repeat (3) tick;
    chk("reset out_valid", ov1, 0);
    chk("reset out_data", od1, 0);
    chk("reset in_ready", rdy1, 0);
    chk("reset out_valid x4", ov4, 0);
    rst = 0;
    #1;
    chk("idle in_ready", rdy1, 1);
    for (int i = 0; i < 4; i++) begin
      xfer1(tv[i].din, 0, res, lat);
      chk("vector data", res, tv[i].exp);
      chk("vector latency", lat, 4);
    end
    repeat (30) begin
      x = rnd();
      xfer1(x, 0, res, lat);
      chk("random data", res, model(x, 0));
      chk("random latency", lat, 4);
    end
    x = rnd(); y = rnd();
    xfer1(x, 0, res, lat);
    or1 = 0;
    chk("stall first data", res, model(x, 0));
    v1 = 1; d1 = y;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("stall out_data", od1, model(x, 0));
      chk("stall out_valid", ov1, 1);
      chk("stall in_ready", rdy1, 0);
    end
    or1 = 1;
    tick;
    chk("release out_valid", ov1, 0);
    chk("release in_ready", rdy1, 1);
    tick;
    v1 = 0;
    lat = 0;
    while (!ov1 && lat < 20) begin tick; lat++; end
    chk("post-stall latency", lat, 4);
    chk("post-stall data", od1, model(y, 0));
    n = 0;
    while (!rdy1 && n < 20) begin tick; n++; end
    v1 = 1; d1 = rnd();
    tick;
    v1 = 0;
    tick;
    rst = 1;
    tick;
    chk("midrst out_valid", ov1, 0);
    chk("midrst out_data", od1, 0);
    chk("midrst in_ready", rdy1, 0);
    rst = 0;
    #1;
    chk("midrst idle in_ready", rdy1, 1);
    seen = 0;
    repeat (8) begin tick; seen |= ov1; end
    chk("midrst no stale out_valid", seen, 0);
    for (int i = 0; i < 8; i++) begin
      x = (i == 0) ? tv[0].din : rnd();
      n = 0;
      while (!rdy4 && n < 20) begin tick; n++; end
      chk("x4 in_ready wait", rdy4, 1);
      v4 = 1; d4 = x;
      tick;
      v4 = 0; d4 = rnd();
      lat = 0;
      while (!ov4 && lat < 20) begin tick; lat++; end
      chk("x4 latency", lat, 1);
      chk("x4 data", od4, model(x, 0));
    end
`ifdef INV_MIX_COLUMNS_BYPASS_EN
    x = 128'h00112233445566778899aabbccddeeff;
    xfer1(x, 1, res, lat);
    chk("bypass data", res, x);
    chk("bypass latency", lat, 4);
    xfer1(x, 0, res, lat);
    chk("after bypass data", res, model(x, 0));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
